// File: rtl/fx_bus_pkg.sv
// Shared fx register-bus definitions: command bytes, bus widths and the
// host-master frame state encoding.
package fx_bus_pkg;

  localparam logic [7:0] FX_CMD_WR = 8'h57;
  localparam logic [7:0] FX_CMD_RD = 8'h52;

  localparam int FX_AW = 8;
  localparam int FX_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WSTB,
    RSTB,
    RWAIT,
    TX
  } fx_state_e;

endpackage

// File: rtl/fx_to_cnt.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches TO_CYC-1.
module fx_to_cnt #(
  parameter int TO_CYC = 50000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the final cycle (an arriving byte) suppresses expiry.
  assign expired_o = en_i && !clr_i && (cnt_q == CW'(TO_CYC - 1));

endmodule

// File: rtl/fx_host_master.sv
// Host byte-link to fx register-bus master: decodes write/read frames into
// single-cycle strobes and returns read data as one response byte.
module fx_host_master
  import fx_bus_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int TO_CYC = 50000
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_vld,
  output logic [7:0]       tx_data,
  output logic             tx_vld,
  input  logic             tx_rdy,
  output logic [FX_AW-1:0] fx_waddr,
  output logic [FX_DW-1:0] fx_data,
  output logic             fx_wr,
  output logic [FX_AW-1:0] fx_raddr,
  output logic             fx_rd,
  input  logic [FX_DW-1:0] fx_q,
  output logic             busy,
  output logic             frm_err
);

  fx_state_e        state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [FX_AW-1:0] addr_q, addr_d;
  logic [2:0]       lat_q, lat_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [FX_AW-1:0] fx_waddr_q, fx_waddr_d;
  logic [FX_DW-1:0] fx_data_q, fx_data_d;
  logic [FX_AW-1:0] fx_raddr_q, fx_raddr_d;
  logic             frm_err_q, frm_err_d;
  logic             tx_vld_q, fx_wr_q, fx_rd_q, busy_q;

  logic in_frame;
  logic to_expired;

  assign in_frame = (state_q == ADDR) || (state_q == DATA);

  // Held clear outside ADDR/DATA so every entry into a frame starts from zero.
  fx_to_cnt #(
    .TO_CYC(TO_CYC)
  ) u_to_cnt (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .clr_i    (rx_vld || !in_frame),
    .en_i     (in_frame),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    tx_data_d  = tx_data_q;
    fx_waddr_d = fx_waddr_q;
    fx_data_d  = fx_data_q;
    fx_raddr_d = fx_raddr_q;
    frm_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_vld && rx_data == FX_CMD_WR) begin
          is_wr_d = 1'b1;
          state_d = ADDR;
        end else if (rx_vld && rx_data == FX_CMD_RD) begin
          is_wr_d = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (rx_vld) begin
          addr_d = rx_data;
          if (is_wr_q) begin
            state_d = DATA;
          end else begin
            fx_raddr_d = rx_data;
            state_d    = RSTB;
          end
        end else if (to_expired) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DATA: begin
        if (rx_vld) begin
          fx_waddr_d = addr_q;
          fx_data_d  = rx_data;
          state_d    = WSTB;
        end else if (to_expired) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WSTB: begin
        frm_err_d = rx_vld;
        state_d   = IDLE;
      end
      RSTB: begin
        frm_err_d = rx_vld;
        lat_d     = '0;
        state_d   = RWAIT;
      end
      RWAIT: begin
        frm_err_d = rx_vld;
        // RWAIT lasts RD_LAT cycles; fx_q is valid in the last one.
        if (lat_q == 3'(RD_LAT - 1)) begin
          tx_data_d = fx_q;
          state_d   = TX;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      TX: begin
        frm_err_d = rx_vld;
        if (tx_vld_q && tx_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      lat_q      <= '0;
      tx_data_q  <= '0;
      fx_waddr_q <= '0;
      fx_data_q  <= '0;
      fx_raddr_q <= '0;
      frm_err_q  <= 1'b0;
      tx_vld_q   <= 1'b0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      tx_data_q  <= tx_data_d;
      fx_waddr_q <= fx_waddr_d;
      fx_data_q  <= fx_data_d;
      fx_raddr_q <= fx_raddr_d;
      frm_err_q  <= frm_err_d;
      tx_vld_q   <= (state_d == TX);
      fx_wr_q    <= (state_d == WSTB);
      fx_rd_q    <= (state_d == RSTB);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_vld   = tx_vld_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_data  = fx_data_q;
  assign fx_wr    = fx_wr_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_rd    = fx_rd_q;
  assign busy     = busy_q;
  assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_fx_host_master.sv
// Directed bench for fx_host_master: two instances (RD_LAT 2 and 5, TO_CYC 100)
// share the host byte stream; each has its own fx_q slave model.
module tb_fx_host_master;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       tx_rdy;
  logic [7:0] rd_val;

  logic [7:0] tx_data_a, fx_waddr_a, fx_data_a, fx_raddr_a, fx_q_a;
  logic       tx_vld_a, fx_wr_a, fx_rd_a, busy_a, frm_err_a;
  logic [7:0] tx_data_b, fx_waddr_b, fx_data_b, fx_raddr_b, fx_q_b;
  logic       tx_vld_b, fx_wr_b, fx_rd_b, busy_b, frm_err_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_sys = ~clk_sys;

  fx_host_master #(.RD_LAT(2), .TO_CYC(100)) u_dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data_a), .tx_vld(tx_vld_a), .tx_rdy(tx_rdy),
    .fx_waddr(fx_waddr_a), .fx_data(fx_data_a), .fx_wr(fx_wr_a),
    .fx_raddr(fx_raddr_a), .fx_rd(fx_rd_a), .fx_q(fx_q_a),
    .busy(busy_a), .frm_err(frm_err_a)
  );

  fx_host_master #(.RD_LAT(5), .TO_CYC(100)) u_dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data_b), .tx_vld(tx_vld_b), .tx_rdy(tx_rdy),
    .fx_waddr(fx_waddr_b), .fx_data(fx_data_b), .fx_wr(fx_wr_b),
    .fx_raddr(fx_raddr_b), .fx_rd(fx_rd_b), .fx_q(fx_q_b),
    .busy(busy_b), .frm_err(frm_err_b)
  );

  // Slave model: h[k] is fx_rd k cycles ago. Valid data only at exactly
  // RD_LAT cycles; distinct decoys one cycle early (11) and late (22).
  logic [7:0] hist_a = '0;
  logic [7:0] hist_b = '0;
  logic [8:0] h_a, h_b;
  assign h_a = {hist_a, fx_rd_a};
  assign h_b = {hist_b, fx_rd_b};
  always @(posedge clk_sys) begin
    hist_a <= {hist_a[6:0], fx_rd_a};
    hist_b <= {hist_b[6:0], fx_rd_b};
  end
  assign fx_q_a = h_a[2] ? rd_val : h_a[1] ? 8'h11 : h_a[3] ? 8'h22 : 8'h00;
  assign fx_q_b = h_b[5] ? rd_val : h_b[4] ? 8'h11 : h_b[6] ? 8'h22 : 8'h00;

  int cnt_wr_a = 0, cnt_rd_a = 0, cnt_err_a = 0, cnt_hs_a = 0, cnt_hs_b = 0, both_a = 0;
  always @(negedge clk_sys) begin
    if (fx_wr_a) cnt_wr_a <= cnt_wr_a + 1;
    if (fx_rd_a) cnt_rd_a <= cnt_rd_a + 1;
    if (frm_err_a) cnt_err_a <= cnt_err_a + 1;
    if (tx_vld_a && tx_rdy) cnt_hs_a <= cnt_hs_a + 1;
    if (tx_vld_b && tx_rdy) cnt_hs_b <= cnt_hs_b + 1;
    if (fx_wr_a && fx_rd_a) both_a <= both_a + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rx_vld pulse; returns #1 into the cycle after the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_sys); #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk_sys); #1;
    rx_vld  = 1'b0;
    $display("[%0t] rx byte %02h", $time, b);
  endtask

  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  initial begin
    int e0, w0, r0, hs0, hsb0, lat_a, lat_b, first, bad;
    logic [7:0] dat_a, dat_b;
    rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; tx_rdy = 1'b1; rd_val = 8'h5A;
    repeat (3) step();
    check("reset_outs_a", {tx_data_a, tx_vld_a, fx_waddr_a, fx_data_a, fx_wr_a,
                           fx_raddr_a, fx_rd_a, busy_a, frm_err_a}, 64'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Write frame with 3-cycle gaps.
    w0 = cnt_wr_a;
    send_byte(8'h57); repeat (3) step();
    send_byte(8'h3C); repeat (3) step();
    send_byte(8'hA5);
    check("wr_strobe", fx_wr_a, 1);
    check("wr_addr", fx_waddr_a, 8'h3C);
    check("wr_data", fx_data_a, 8'hA5);
    check("wr_busy", busy_a, 1);
    step();
    check("wr_strobe_end", fx_wr_a, 0);
    check("wr_busy_fall", busy_a, 0);
    check("wr_addr_hold", fx_waddr_a, 8'h3C);
    check("wr_count", cnt_wr_a - w0, 1);

    // Read latency, both RD_LAT values.
    hs0 = cnt_hs_a; hsb0 = cnt_hs_b;
    send_byte(8'h52); send_byte(8'h10);
    check("rd_strobe_a", fx_rd_a, 1);
    check("rd_addr_a", fx_raddr_a, 8'h10);
    check("rd_strobe_b", fx_rd_b, 1);
    lat_a = -1; lat_b = -1; dat_a = 8'h00; dat_b = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (tx_vld_a && lat_a < 0) begin lat_a = c; dat_a = tx_data_a; end
      if (tx_vld_b && lat_b < 0) begin lat_b = c; dat_b = tx_data_b; end
    end
    check("rd_lat2_cycles", lat_a, 3);
    check("rd_lat2_data", dat_a, 8'h5A);
    check("rd_lat5_cycles", lat_b, 6);
    check("rd_lat5_data", dat_b, 8'h5A);
    check("rd_resp_a", cnt_hs_a - hs0, 1);
    check("rd_resp_b", cnt_hs_b - hsb0, 1);
    check("rd_busy_a", busy_a, 0);

    // Stalled response plus a byte dropped during TX.
    rd_val = 8'h96; tx_rdy = 1'b0;
    send_byte(8'h52); send_byte(8'h44);
    repeat (12) step();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!tx_vld_a || tx_data_a !== 8'h96 || !tx_vld_b || tx_data_b !== 8'h96) bad++;
      step();
    end
    e0 = cnt_err_a; r0 = cnt_rd_a;
    send_byte(8'h52);
    check("tx_drop_err", frm_err_a, 1);
    check("tx_drop_err_b", frm_err_b, 1);
    step();
    check("tx_drop_err_pulse", frm_err_a, 0);
    for (int c = 0; c < 10; c++) begin
      if (!tx_vld_a || tx_data_a !== 8'h96 || !tx_vld_b || tx_data_b !== 8'h96) bad++;
      step();
    end
    check("tx_hold_stable", bad, 0);
    hs0 = cnt_hs_a; hsb0 = cnt_hs_b;
    tx_rdy = 1'b1;
    repeat (3) step();
    check("tx_single_resp_a", cnt_hs_a - hs0, 1);
    check("tx_single_resp_b", cnt_hs_b - hsb0, 1);
    check("tx_idle_after", busy_a, 0);
    check("tx_drop_no_frame", cnt_rd_a - r0, 0);
    check("tx_err_count", cnt_err_a - e0, 1);

    // Timeout after the address byte of a write.
    e0 = cnt_err_a; w0 = cnt_wr_a;
    send_byte(8'h57); send_byte(8'h22);
    first = -1;
    for (int c = 0; c < 120; c++) begin
      if (frm_err_a && first < 0) first = c;
      step();
    end
    check("to_fire_cycle", first, 100);
    check("to_err_count", cnt_err_a - e0, 1);
    check("to_no_write", cnt_wr_a - w0, 0);
    check("to_idle", busy_a, 0);
    send_byte(8'h57); send_byte(8'h22); send_byte(8'h01);
    check("to_recover_wr", fx_wr_a, 1);
    check("to_recover_addr", fx_waddr_a, 8'h22);
    check("to_recover_data", fx_data_a, 8'h01);

    // Byte arriving in the expiry cycle wins over the timeout.
    step();
    e0 = cnt_err_a;
    send_byte(8'h57);
    repeat (98) @(posedge clk_sys);
    send_byte(8'h33);
    send_byte(8'h77);
    check("to_edge_wr", fx_wr_a, 1);
    check("to_edge_addr", fx_waddr_a, 8'h33);
    check("to_edge_data", fx_data_a, 8'h77);
    check("to_edge_no_err", cnt_err_a - e0, 0);

    // Garbage bytes in IDLE, then a normal read.
    step();
    e0 = cnt_err_a; w0 = cnt_wr_a; r0 = cnt_rd_a;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
    step();
    check("garb_busy", busy_a, 0);
    check("garb_no_err", cnt_err_a - e0, 0);
    check("garb_no_strobe", (cnt_wr_a - w0) + (cnt_rd_a - r0), 0);
    rd_val = 8'hC3; hs0 = cnt_hs_a;
    send_byte(8'h52); send_byte(8'h01);
    check("garb_rd_addr", fx_raddr_a, 8'h01);
    repeat (10) step();
    check("garb_rd_resp", cnt_hs_a - hs0, 1);
    check("garb_rd_data", tx_data_a, 8'hC3);

    // Reset during RWAIT.
    send_byte(8'h52); send_byte(8'h10);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_outs_a", {tx_data_a, tx_vld_a, fx_waddr_a, fx_data_a, fx_wr_a,
                         fx_raddr_a, fx_rd_a, busy_a, frm_err_a}, 64'd0);
    check("rst_busy_b", busy_b, 0);
    step();
    rst_n = 1'b1;
    hs0 = cnt_hs_a; hsb0 = cnt_hs_b;
    repeat (15) step();
    check("rst_no_resp_a", cnt_hs_a - hs0, 0);
    check("rst_no_resp_b", cnt_hs_b - hsb0, 0);
    check("rst_idle", {busy_a, tx_vld_a}, 0);
    check("no_wr_rd_overlap", both_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
